// File: rtl/sha256_pkg.sv
// SHA-256 constants, state encoding and the FIPS 180-4 mixing functions.
// Shared by the compression core, its message scheduler and upstream padding logic.
package sha256_pkg;

    localparam int ROUNDS  = 64;
    localparam int T_WIDTH = 6;

    typedef logic [T_WIDTH-1:0] rnd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2
    } state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block/chaining-value request and digest result bundle for the compression core.
// master = upstream sequencer, slave = sha256_compress.
interface sha256_compress_if;
    import sha256_pkg::*;

    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    modport master (
        output start, block_in, hash_in,
        input  busy, done, hash_out
    );

    modport slave (
        input  start, block_in, hash_in,
        output busy, done, hash_out
    );

endinterface

// File: rtl/sha256_msg_sched.sv
// Purpose: 16-word W window; W[0] feeds the current round, W[15] takes the expanded word.
// Latency: load captures the block in one edge, each shift advances one round.
// Backpressure: none; the core owns load/shift timing.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  w0
);

    logic [31:0] w [16];
    logic [31:0] w_new;

    // W[t+16] expressed relative to the sliding window.
    assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    assign w0    = w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= block_in[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i+1];
            end
            w[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Purpose: iterative SHA-256 compression, one round per clock, feed-forward add at the end.
// Latency: done pulses 66 clocks after start is asserted; one block per 66 cycles.
// Backpressure: start is ignored while busy and never queued.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sha256_compress_if.slave  bus
);

    state_t      state;
    rnd_t        t;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] hv [8];
    logic        busy_r;
    logic        done_r;
    logic [255:0] hash_r;

    logic        sched_load;
    logic        sched_shift;
    logic [31:0] w0;
    logic [31:0] t1;
    logic [31:0] t2;

    assign sched_load  = (state == IDLE) && bus.start;
    assign sched_shift = (state == ROUND);

    sha256_msg_sched u_msg_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sched_load),
        .shift    (sched_shift),
        .block_in (bus.block_in),
        .w0       (w0)
    );

    always_comb begin
        t1 = h + big_sigma1(e) + ch(e, f, g) + K[t] + w0;
        t2 = big_sigma0(a) + maj(a, b, c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            t      <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= '0;
            end
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hash_r <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        {a, b, c, d, e, f, g, h} <= bus.hash_in;
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= bus.hash_in[255 - 32*i -: 32];
                        end
                        t      <= '0;
                        busy_r <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    // t parks at 63 so K/W indexing never aliases back to round 0.
                    if (t == rnd_t'(ROUNDS - 1)) begin
                        state <= ADD;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ADD: begin
                    hash_r <= {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                               hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.hash_out = hash_r;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed known-answer bench for sha256_compress: FIPS 180-4 digests plus reset/handshake corners.
module tb_sha256_compress;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_compress_if bus();

    sha256_compress dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [255:0] hin;
        logic [255:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_TWO2  = {448'h0, 64'h1c0};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO   =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [511:0] blk, input logic [255:0] hin);
        bus.block_in = blk;
        bus.hash_in  = hin;
        bus.start    = 1'b1;
    endtask

    // Counts edges from the start-sampling edge until done; 100 means it never came.
    task automatic wait_done(output int lat, output logic busy_first, output logic [255:0] mid);
        lat = 0;
        busy_first = 1'b0;
        mid = '0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                busy_first = bus.busy;
                bus.start = 1'b0;
            end
            if (lat == 33) mid = bus.hash_out;
            if (bus.done) break;
        end
    endtask

    initial begin
        vec_t         v [2];
        int           lat;
        int           pulses;
        logic         bf;
        logic [255:0] mid;
        logic [255:0] h1;

        v[0] = '{name: "abc",   blk: BLK_ABC,   hin: SHA256_IV, exp: DIG_ABC};
        v[1] = '{name: "empty", blk: BLK_EMPTY, hin: SHA256_IV, exp: DIG_EMPTY};

        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.hash_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 256'(bus.busy), 256'd0);
        chk("reset_done", 256'(bus.done), 256'd0);
        chk("reset_hash", bus.hash_out, 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            launch(v[i].blk, v[i].hin);
            wait_done(lat, bf, mid);
            chk({v[i].name, "_latency"}, 256'(lat), 256'd66);
            chk({v[i].name, "_busy_rise"}, 256'(bf), 256'd1);
            chk({v[i].name, "_digest"}, bus.hash_out, v[i].exp);
            chk({v[i].name, "_busy_at_done"}, 256'(bus.busy), 256'd0);
            @(posedge clk);
            #1;
            chk({v[i].name, "_done_one_cycle"}, 256'(bus.done), 256'd0);
            chk({v[i].name, "_hash_held"}, bus.hash_out, v[i].exp);
        end

        // Two-block chain, second start issued in the done cycle.
        launch(BLK_TWO1, SHA256_IV);
        wait_done(lat, bf, mid);
        chk("two_blk1_latency", 256'(lat), 256'd66);
        h1 = bus.hash_out;
        launch(BLK_TWO2, h1);
        wait_done(lat, bf, mid);
        chk("two_blk2_latency", 256'(lat), 256'd66);
        chk("two_no_idle_gap", 256'(bf), 256'd1);
        chk("two_hash_stable_midrun", mid, h1);
        chk("two_digest", bus.hash_out, DIG_TWO);

        // start held high and inputs scrambled while busy.
        @(posedge clk);
        #1;
        launch(BLK_ABC, SHA256_IV);
        pulses = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                bus.block_in = ~BLK_ABC;
                bus.hash_in  = ~SHA256_IV;
            end
            if (cyc == 60) bus.start = 1'b0;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) begin
                    lat = cyc;
                    chk("held_start_digest", bus.hash_out, DIG_ABC);
                end
            end
        end
        chk("held_start_latency", 256'(lat), 256'd66);
        chk("held_start_pulses", 256'(pulses), 256'd1);

        // Reset asserted at round 30.
        launch(BLK_ABC, SHA256_IV);
        for (int k = 0; k < 31; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("midrun_busy_before_reset", 256'(bus.busy), 256'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", 256'(bus.busy), 256'd0);
        chk("midrun_reset_done", 256'(bus.done), 256'd0);
        chk("midrun_reset_hash", bus.hash_out, 256'd0);
        #2;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("midrun_no_done_after_reset", 256'(pulses), 256'd0);
        launch(BLK_ABC, SHA256_IV);
        wait_done(lat, bf, mid);
        chk("after_reset_latency", 256'(lat), 256'd66);
        chk("after_reset_digest", bus.hash_out, DIG_ABC);

        // start already high when reset releases: first edge must accept it.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        launch(BLK_EMPTY, SHA256_IV);
        #2;
        rst_n = 1'b1;
        wait_done(lat, bf, mid);
        chk("release_start_busy_rise", 256'(bf), 256'd1);
        chk("release_start_latency", 256'(lat), 256'd66);
        chk("release_start_digest", bus.hash_out, DIG_EMPTY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
